// File: rtl/pmc_dc_bm_pkg.sv
// Shared types for the PMC data-bus master: FSM states and the queued command word.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package pmc_dc_bm_pkg;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT_RVALID,
        RSP
    } pmc_dc_bm_state_e;

    typedef struct packed {
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
    } pmc_dc_bm_cmd_t;

endpackage

// File: rtl/pmc_dc_bm_fifo.sv
// Synchronous command FIFO; extra pointer MSB tells full from empty.
// Latency: a pushed entry is visible at the head on the next cycle (no bypass).
// Backpressure: a push while full and a pop while empty are both ignored.
module pmc_dc_bm_fifo
    import pmc_dc_bm_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           push,
    input  pmc_dc_bm_cmd_t push_dat,
    input  logic           pop,
    output pmc_dc_bm_cmd_t pop_dat,
    output logic           full,
    output logic           empty
);

    localparam int AW = $clog2(DEPTH);

    pmc_dc_bm_cmd_t mem [DEPTH];
    logic [AW:0]    wr_ptr;
    logic [AW:0]    rd_ptr;
    logic           do_push;
    logic           do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage carries no reset; only the pointers define validity.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_dat;
    end

    assign pop_dat = mem[rd_ptr[AW-1:0]];
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/pmc_dc_bus_master.sv
// Queues register commands and issues them one at a time on the data bus, one in-order response each.
// Latency: command accepted in cycle 0 gives bus_req in cycle 2; rvalid in cycle k gives rsp_valid in k+1.
// Backpressure: cmd_ready drops when the queue is full; the FSM holds in RSP until rsp_ready.
module pmc_dc_bus_master
    import pmc_dc_bm_pkg::*;
#(
    parameter int CMD_FIFO_DEPTH = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_we,
    input  logic [3:0]  cmd_be,
    input  logic [31:0] cmd_addr,
    input  logic [31:0] cmd_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        busy,
    output logic        bus_req,
    input  logic        bus_gnt,
    input  logic        bus_rvalid,
    input  logic        bus_err,
    output logic        bus_we,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic [31:0] bus_rdata
);

    localparam int TW       = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam int TO_LAST_I = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
    localparam logic [TW-1:0] TO_LAST = TO_LAST_I[TW-1:0];
    localparam logic [TW-1:0] TO_SAT  = TIMEOUT_CYCLES[TW-1:0];

    pmc_dc_bm_state_e state_q;
    pmc_dc_bm_state_e state_d;

    pmc_dc_bm_cmd_t   push_cmd;
    pmc_dc_bm_cmd_t   head_cmd;
    logic             fifo_push;
    logic             fifo_pop;
    logic             fifo_full;
    logic             fifo_empty;

    logic [TW-1:0]    to_cnt;
    logic             timeout_hit;
    logic             waiting;

    logic             load_cmd;
    logic             rsp_load;
    logic             rsp_err_d;
    logic [31:0]      rsp_rdata_d;

    assign push_cmd  = '{we: cmd_we, be: cmd_be, addr: cmd_addr, wdata: cmd_wdata};
    assign fifo_push = cmd_valid && cmd_ready;

    pmc_dc_bm_fifo #(
        .DEPTH (CMD_FIFO_DEPTH)
    ) u_cmd_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (fifo_push),
        .push_dat (push_cmd),
        .pop      (fifo_pop),
        .pop_dat  (head_cmd),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    assign waiting     = (state_q == REQ) || (state_q == WAIT_RVALID);
    // Fires in the cycle the count would reach TIMEOUT_CYCLES, so the wait lasts exactly that long.
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (to_cnt == TO_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d     = state_q;
        fifo_pop    = 1'b0;
        load_cmd    = 1'b0;
        rsp_load    = 1'b0;
        rsp_err_d   = 1'b0;
        rsp_rdata_d = '0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    state_d  = REQ;
                    load_cmd = 1'b1;
                end
            end
            REQ: begin
                if (bus_gnt) begin
                    fifo_pop = 1'b1;
                    state_d  = WAIT_RVALID;
                end else if (timeout_hit) begin
                    // An ungranted command is still consumed so the sequencer sees one response.
                    fifo_pop  = 1'b1;
                    state_d   = RSP;
                    rsp_load  = 1'b1;
                    rsp_err_d = 1'b1;
                end
            end
            WAIT_RVALID: begin
                if (bus_rvalid) begin
                    state_d     = RSP;
                    rsp_load    = 1'b1;
                    rsp_err_d   = bus_err;
                    rsp_rdata_d = (bus_we || bus_err) ? 32'h0 : bus_rdata;
                end else if (timeout_hit) begin
                    state_d   = RSP;
                    rsp_load  = 1'b1;
                    rsp_err_d = 1'b1;
                end
            end
            RSP: begin
                if (rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus_we    <= 1'b0;
            bus_be    <= '0;
            bus_addr  <= '0;
            bus_wdata <= '0;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
            to_cnt    <= '0;
        end else begin
            if (load_cmd) begin
                bus_we    <= head_cmd.we;
                bus_be    <= head_cmd.be;
                bus_addr  <= head_cmd.addr;
                bus_wdata <= head_cmd.wdata;
            end
            if (rsp_load) begin
                rsp_err   <= rsp_err_d;
                rsp_rdata <= rsp_rdata_d;
            end
            if ((state_d != state_q) && ((state_d == REQ) || (state_d == WAIT_RVALID))) begin
                to_cnt <= '0;
            end else if (waiting && (to_cnt != TO_SAT)) begin
                to_cnt <= to_cnt + 1'b1;
            end
        end
    end

    assign bus_req   = (state_q == REQ);
    assign rsp_valid = (state_q == RSP);
    assign cmd_ready = !fifo_full;
    assign busy      = !fifo_empty || (state_q != IDLE);

endmodule

// File: tb/tb_pmc_dc_bus_master.sv
// Directed bench for pmc_dc_bus_master with a simple bus slave model and response monitor.
module tb_pmc_dc_bus_master;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid, cmd_ready, cmd_we;
    logic [3:0]  cmd_be;
    logic [31:0] cmd_addr, cmd_wdata;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [31:0] rsp_rdata;
    logic        busy;
    logic        bus_req, bus_gnt, bus_rvalid, bus_err, bus_we;
    logic [3:0]  bus_be;
    logic [31:0] bus_addr, bus_wdata, bus_rdata;

    int n_cmp = 0;
    int n_mis = 0;

    // Slave model controls
    int          sl_gnt_dly = 0;
    logic        sl_never   = 1'b0;
    logic        sl_hold    = 1'b0;
    logic        sl_err     = 1'b0;
    logic        sl_fixed   = 1'b0;
    logic [31:0] sl_rdata   = '0;
    logic        force_rv   = 1'b0;

    // Monitor state
    int          req_cycles = 0;
    int          attr_chg   = 0;
    logic [68:0] attr_snap;
    logic [31:0] rq_dat[$];
    logic        rq_err[$];

    always #5 clk = ~clk;

    pmc_dc_bus_master #(
        .CMD_FIFO_DEPTH (4),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_we     (cmd_we),
        .cmd_be     (cmd_be),
        .cmd_addr   (cmd_addr),
        .cmd_wdata  (cmd_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .busy       (busy),
        .bus_req    (bus_req),
        .bus_gnt    (bus_gnt),
        .bus_rvalid (bus_rvalid),
        .bus_err    (bus_err),
        .bus_we     (bus_we),
        .bus_be     (bus_be),
        .bus_addr   (bus_addr),
        .bus_wdata  (bus_wdata),
        .bus_rdata  (bus_rdata)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] slave_rd(input logic [31:0] addr);
        return addr ^ 32'hC0DE_0000;
    endfunction

    // Called at posedge+1; returns at posedge+1 of the cycle after the handshake edge.
    task automatic push(input logic we, input logic [3:0] be, input logic [31:0] addr,
                        input logic [31:0] wdata);
        int n = 0;
        cmd_valid = 1'b1;
        cmd_we    = we;
        cmd_be    = be;
        cmd_addr  = addr;
        cmd_wdata = wdata;
        while (!cmd_ready && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 200) chk("push_wait", {31'b0, cmd_ready}, 32'd1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_rsps(input int n);
        int k = 0;
        while (rq_dat.size() < n && k < 100) begin
            @(posedge clk); #1;
            k++;
        end
        chk("rsp_count", rq_dat.size(), n);
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Bus slave: grants after sl_gnt_dly waiting cycles, answers the cycle after the grant.
    initial begin
        int          gwait = 0;
        logic        pend = 1'b0;
        logic        pend_we = 1'b0;
        logic [31:0] pend_addr = '0;
        bus_gnt = 0; bus_rvalid = 0; bus_err = 0; bus_rdata = '0;
        forever begin
            @(posedge clk); #3;
            bus_gnt = 0; bus_rvalid = 0; bus_err = 0; bus_rdata = '0;
            if (!rst_n) begin
                pend  = 1'b0;
                gwait = 0;
            end else begin
                if (pend) begin
                    bus_rvalid = 1'b1;
                    bus_err    = sl_err;
                    bus_rdata  = pend_we ? 32'h0BAD_0000 : (sl_fixed ? sl_rdata : slave_rd(pend_addr));
                    pend       = 1'b0;
                end else if (force_rv) begin
                    bus_rvalid = 1'b1;
                    bus_rdata  = 32'h5555_AAAA;
                end
                if (bus_req && !sl_never) begin
                    if (gwait >= sl_gnt_dly) begin
                        bus_gnt   = 1'b1;
                        gwait     = 0;
                        pend      = !sl_hold;
                        pend_we   = bus_we;
                        pend_addr = bus_addr;
                    end else begin
                        gwait++;
                    end
                end
            end
        end
    end

    // Request-cycle counter, attribute stability and response capture.
    initial begin
        forever begin
            @(posedge clk); #4;
            if (bus_req) begin
                if (req_cycles == 0) attr_snap = {bus_we, bus_be, bus_addr, bus_wdata};
                else if ({bus_we, bus_be, bus_addr, bus_wdata} != attr_snap) attr_chg++;
                req_cycles++;
            end
            if (rsp_valid && rsp_ready) begin
                rq_dat.push_back(rsp_rdata);
                rq_err.push_back(rsp_err);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic        exp_we[6];
        logic [31:0] exp_addr[6];

        rst_n = 1'b0;
        cmd_valid = 0; cmd_we = 0; cmd_be = '0; cmd_addr = '0; cmd_wdata = '0;
        rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        chk("rst_cmd_ready", {31'b0, cmd_ready}, 32'd1);
        chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        chk("rst_busy",      {31'b0, busy},      32'd0);
        chk("rst_bus_req",   {31'b0, bus_req},   32'd0);
        chk("rst_rsp_rdata", rsp_rdata,          32'd0);
        chk("rst_bus_addr",  bus_addr,           32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        idle_cycles(2);

        // 1: write, immediate grant, response next cycle
        req_cycles = 0; attr_chg = 0;
        push(1'b1, 4'hF, 32'h0000_0004, 32'hDEAD_BEEF);
        #1;
        chk("t1_req_c1",  {31'b0, bus_req}, 32'd0);
        chk("t1_busy_c1", {31'b0, busy},    32'd1);
        @(posedge clk); #2;
        chk("t1_req_c2",  {31'b0, bus_req}, 32'd1);
        chk("t1_we",      {31'b0, bus_we},  32'd1);
        chk("t1_be",      {28'b0, bus_be},  32'hF);
        chk("t1_addr",    bus_addr,         32'h0000_0004);
        chk("t1_wdata",   bus_wdata,        32'hDEAD_BEEF);
        @(posedge clk); #2;
        chk("t1_req_c3",  {31'b0, bus_req},   32'd0);
        chk("t1_rspv_c3", {31'b0, rsp_valid}, 32'd0);
        @(posedge clk); #2;
        chk("t1_rspv_c4", {31'b0, rsp_valid}, 32'd1);
        chk("t1_err",     {31'b0, rsp_err},   32'd0);
        chk("t1_rdata",   rsp_rdata,          32'd0);
        chk("t1_reqcyc",  req_cycles,         32'd1);
        idle_cycles(3);

        // 2: read, grant after 3 waiting cycles
        rq_dat.delete(); rq_err.delete();
        req_cycles = 0; attr_chg = 0;
        sl_gnt_dly = 3; sl_fixed = 1'b1; sl_rdata = 32'h1234_5678;
        push(1'b0, 4'hF, 32'h0000_0000, 32'h0);
        wait_rsps(1);
        chk("t2_reqcyc",   req_cycles, 32'd4);
        chk("t2_attr_chg", attr_chg,   32'd0);
        if (rq_dat.size() >= 1) begin
            chk("t2_rdata", rq_dat[0],           32'h1234_5678);
            chk("t2_err",   {31'b0, rq_err[0]},  32'd0);
        end
        sl_gnt_dly = 0; sl_fixed = 1'b0;
        idle_cycles(3);

        // 3: six commands with responses held off
        rq_dat.delete(); rq_err.delete();
        rsp_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            exp_we[i]   = (i % 2 == 0);
            exp_addr[i] = 32'h100 + 32'(4 * i);
        end
        for (int i = 0; i < 5; i++) push(exp_we[i], 4'hF, exp_addr[i], 32'h1111_1111 * 32'(i));
        idle_cycles(3);
        #1;
        chk("t3_cmd_ready_full", {31'b0, cmd_ready}, 32'd0);
        chk("t3_rsp_held",       {31'b0, rsp_valid}, 32'd1);
        chk("t3_none_consumed",  rq_dat.size(),      32'd0);
        rsp_ready = 1'b1;
        push(exp_we[5], 4'hF, exp_addr[5], 32'h5555_5555);
        wait_rsps(6);
        for (int i = 0; i < 6; i++) begin
            if (i < rq_dat.size()) begin
                chk($sformatf("t3_rdata%0d", i), rq_dat[i],
                    exp_we[i] ? 32'h0 : slave_rd(exp_addr[i]));
                chk($sformatf("t3_err%0d", i), {31'b0, rq_err[i]}, 32'd0);
            end
        end
        idle_cycles(3);

        // 4: slave never grants -> timeout after 8 request cycles
        rq_dat.delete(); rq_err.delete();
        req_cycles = 0;
        sl_never = 1'b1;
        push(1'b0, 4'hF, 32'h0000_0040, 32'h0);
        wait_rsps(1);
        chk("t4_reqcyc", req_cycles, 32'd8);
        if (rq_dat.size() >= 1) begin
            chk("t4_err",   {31'b0, rq_err[0]}, 32'd1);
            chk("t4_rdata", rq_dat[0],          32'd0);
        end
        sl_never = 1'b0;
        idle_cycles(2);
        chk("t4_idle", {31'b0, busy}, 32'd0);
        rq_dat.delete(); rq_err.delete();
        push(1'b0, 4'hF, 32'h0000_0044, 32'h0);
        wait_rsps(1);
        if (rq_dat.size() >= 1) begin
            chk("t4_next_err",   {31'b0, rq_err[0]}, 32'd0);
            chk("t4_next_rdata", rq_dat[0],          slave_rd(32'h0000_0044));
        end
        idle_cycles(3);

        // 5: bus error on a read zeroes the data
        rq_dat.delete(); rq_err.delete();
        sl_err = 1'b1; sl_fixed = 1'b1; sl_rdata = 32'hFFFF_FFFF;
        push(1'b0, 4'hF, 32'h0000_0008, 32'h0);
        wait_rsps(1);
        if (rq_dat.size() >= 1) begin
            chk("t5_err",   {31'b0, rq_err[0]}, 32'd1);
            chk("t5_rdata", rq_dat[0],          32'd0);
        end
        sl_err = 1'b0; sl_fixed = 1'b0;
        idle_cycles(3);

        // 6: reset while waiting for rvalid, late rvalid afterwards
        rq_dat.delete(); rq_err.delete();
        sl_hold = 1'b1;
        push(1'b0, 4'hF, 32'h0000_0200, 32'h0);
        push(1'b1, 4'h3, 32'h0000_0204, 32'hCAFE_F00D);
        idle_cycles(2);
        rst_n = 1'b0;
        #1;
        chk("t6_req_in_rst",   {31'b0, bus_req},   32'd0);
        chk("t6_busy_in_rst",  {31'b0, busy},      32'd0);
        chk("t6_ready_in_rst", {31'b0, cmd_ready}, 32'd1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        sl_hold = 1'b0;
        force_rv = 1'b1;
        @(posedge clk); #1;
        force_rv = 1'b0;
        idle_cycles(4);
        #1;
        chk("t6_no_rsp",    rq_dat.size(),      32'd0);
        chk("t6_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        chk("t6_busy",      {31'b0, busy},      32'd0);
        chk("t6_bus_req",   {31'b0, bus_req},   32'd0);
        chk("t6_rsp_err",   {31'b0, rsp_err},   32'd0);
        chk("t6_rsp_rdata", rsp_rdata,          32'd0);
        chk("t6_bus_addr",  bus_addr,           32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
